hazard_stall_ctl: RTL
=====================

// Module: hazard_stall_ctl
// PURPOSE
// Pipeline sequencing controller for the IF/ID, ID/EX and EX/MEM latches. It detects load-use
// hazards, taken-branch redirects and data-memory wait states. From these it drives per-latch
// write enables, bubble (zero control fields) and flush controls, plus the PC write/redirect
// controls. It sits beside the decode stage and observes ID operands, EX control and MEM status.
// PARAMETERS
// MAX_WAIT  16  max consecutive mem_busy cycles before the sticky timeout error (>=2)
// CNT_W     16  width of the saturating stall/flush performance counters
// PORTS
// clk               in   1      rising-edge clock
// rst_n             in   1      asynchronous active-low reset
// id_valid          in   1      IF/ID holds a real instruction
// id_rs             in   5      decode-stage rs field
// id_rt             in   5      decode-stage rt field
// id_uses_rt        in   1      decode instruction reads rt as a source
// ex_mem_read       in   1      ID/EX mem control indicates a load in EX
// ex_rt             in   5      destination register of the load in EX
// mem_branch_taken  in   1      branch resolved taken in MEM stage
// mem_busy          in   1      data memory not ready this cycle
// pc_write          out  1      PC register enable
// pc_redirect       out  1      PC mux selects branch target
// ifid_write        out  1      IF/ID enable
// ifid_flush        out  1      IF/ID clear to NOP
// idex_write        out  1      ID/EX enable
// idex_bubble       out  1      ID/EX loads zero wb/mem/ex controls
// exmem_write       out  1      EX/MEM enable
// exmem_bubble      out  1      EX/MEM loads zero wb/mem controls
// mem_timeout       out  1      sticky error: memory wait exceeded MAX_WAIT
// state             out  2      FSM state: 0 RUN, 1 STALL, 2 WAIT, 3 ERR
// stall_cnt         out  CNT_W  load-use stalls inserted (saturating)
// flush_cnt         out  CNT_W  branch flushes performed (saturating)
// BEHAVIOUR
// - Reset (rst_n low, async): state=RUN, wait_cnt=0, counters=0, mem_timeout=0. While rst_n is low,
//   all *_write=0 and all bubble/flush/redirect=0.
// - Control outputs are combinational from state plus current inputs, taking effect at the same edge.
//   State, wait_cnt, counters and mem_timeout are registered.
// - hazard = id_valid & ex_mem_read & (ex_rt!=0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
// - Per-cycle priority, highest first:
//   1 state==ERR: all writes=0, no bubble/flush. Stay ERR until reset. mem_timeout=1.
//   2 mem_busy: all writes=0 (full freeze), no bubble/flush. Next=WAIT, wait_cnt++.
//     If wait_cnt==MAX_WAIT-1, next=ERR and mem_timeout<=1.
//   3 mem_branch_taken: all writes=1, pc_write=1, pc_redirect=1, ifid_flush=1,
//     idex_bubble=1, exmem_bubble=1. flush_cnt++. Next=RUN.
//   4 hazard: pc_write=0, ifid_write=0, idex_write=1, idex_bubble=1, exmem_write=1.
//     stall_cnt++. Next=STALL.
//   5 otherwise: all writes=1, no bubble/flush. Next=RUN.
// - wait_cnt clears whenever mem_busy=0. It counts consecutive busy cycles only.
// - Branch with mem_busy: freeze wins. EX/MEM is frozen, so mem_branch_taken stays asserted and
//   the flush fires on the first cycle mem_busy=0. flush_cnt increments once.
// - Load-use stall is one cycle: the bubble clears ex_mem_read next cycle. A hazard seen again in
//   STALL stalls again and increments the count again.
// - Counters saturate at all-ones and never wrap.
// - Reset asserted mid-WAIT or in ERR returns to RUN immediately and clears mem_timeout.
// TESTING
// - ex_mem_read=1, ex_rt=5, id_rs=5, id_valid=1 -> one cycle with pc_write=0, ifid_write=0,
//   idex_bubble=1, state=STALL, stall_cnt=1. Next cycle (ex_mem_read=0) -> all writes=1, RUN.
// - ex_rt=0 = id_rs, ex_mem_read=1 -> no stall. Same with id_rt match, id_uses_rt=0 -> no stall.
// - mem_branch_taken=1 coinciding with hazard -> ifid_flush=idex_bubble=exmem_bubble=pc_redirect=1,
//   flush_cnt=1, stall_cnt=0.
// - mem_busy high 3 cycles with mem_branch_taken=1 -> 3 freeze cycles (all writes 0), then one
//   flush cycle, flush_cnt=1.
// - MAX_WAIT=4, mem_busy held high -> ERR after 4th busy cycle, mem_timeout=1 and writes stay 0
//   after mem_busy falls. Pulse rst_n low -> state=RUN, mem_timeout=0.
// - CNT_W=2, 5 load-use stalls -> stall_cnt holds at 3.

Source files
------------

// File: rtl/hazard_stall_ctl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes and memory-wait freezes
// for the IF/ID, ID/EX and EX/MEM latches, with saturating stall/flush counters.
module hazard_stall_ctl #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             pc_redirect,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic             exmem_bubble,
  output logic             mem_timeout,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StWait  = 2'd2,
    StErr   = 2'd3
  } state_e;

  localparam int unsigned WaitW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   flush_q, flush_d;
  logic               timeout_q, timeout_d;
  logic               hazard;

  assign hazard = id_valid & ex_mem_read & (ex_rt != 5'd0) &
                  ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    stall_d      = stall_q;
    flush_d      = flush_q;
    timeout_d    = timeout_q;
    pc_write     = 1'b0;
    pc_redirect  = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idex_write   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b0;
    exmem_bubble = 1'b0;

    // Controls stay deasserted while reset is held; registers are cleared by the async reset.
    if (!rst_n || state_q == StErr) begin
      timeout_d = 1'b1;
    end else if (mem_busy) begin
      if (wait_q == WaitW'(MAX_WAIT - 1)) begin
        state_d   = StErr;
        timeout_d = 1'b1;
      end else begin
        state_d = StWait;
        wait_d  = wait_q + WaitW'(1);
      end
    end else begin
      wait_d = '0;
      if (mem_branch_taken) begin
        pc_write     = 1'b1;
        pc_redirect  = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b1;
        idex_write   = 1'b1;
        idex_bubble  = 1'b1;
        exmem_write  = 1'b1;
        exmem_bubble = 1'b1;
        state_d      = StRun;
        if (flush_q != '1) flush_d = flush_q + CNT_W'(1);
      end else if (hazard) begin
        idex_write  = 1'b1;
        idex_bubble = 1'b1;
        exmem_write = 1'b1;
        state_d     = StStall;
        if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
      end else begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        state_d     = StRun;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      wait_q    <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
      timeout_q <= timeout_d;
    end
  end

  assign state       = state_q;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;
  assign mem_timeout = timeout_q;

endmodule
